// File: rtl/mem_lsu.sv
// Load/store initiator for the word-wide big-endian RAM: one CPU byte/half/word access
// becomes a RAM read, write, or read-modify-write sequence.
`ifndef RAM_NOP
`define RAM_NOP   2'b00
`endif
`ifndef RAM_READ
`define RAM_READ  2'b01
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'b10
`endif

module mem_lsu #(
  parameter int MEM_SIZE = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_ram_action,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_val,
  input  logic [31:0] i_ram_val
);
  localparam logic [31:0] LAST = 32'(MEM_SIZE - 4);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        we, sgn, err, bad;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rd, load_val, merge_val;

  // the whole 4-byte window must be inside RAM, even for byte accesses
  assign bad = (i_size == 2'b11) || (i_addr > LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_req) begin
        if (bad)                          state_nxt = DONE;
        else if (!i_we || i_size != 2'b10) state_nxt = RD;
        else                              state_nxt = WR;
      end
      RD:      state_nxt = we ? WR : DONE;
      WR:      state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_val = i_ram_val;
    case (size)
      2'b00:   load_val = sgn ? {{24{i_ram_val[31]}}, i_ram_val[31:24]}
                              : {24'd0, i_ram_val[31:24]};
      2'b01:   load_val = sgn ? {{16{i_ram_val[31]}}, i_ram_val[31:16]}
                              : {16'd0, i_ram_val[31:16]};
      default: load_val = i_ram_val;
    endcase
  end

  always_comb begin
    merge_val = wdata;
    case (size)
      2'b00:   merge_val = {wdata[7:0], rd[23:0]};
      2'b01:   merge_val = {wdata[15:0], rd[15:0]};
      default: merge_val = wdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      we      <= 1'b0;
      sgn     <= 1'b0;
      err     <= 1'b0;
      size    <= 2'b00;
      addr    <= '0;
      wdata   <= '0;
      rd      <= '0;
      o_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_req) begin
        we    <= i_we;
        sgn   <= i_signed;
        size  <= i_size;
        addr  <= i_addr;
        wdata <= i_wdata;
        err   <= bad;
      end
      if (state == RD) begin
        rd <= i_ram_val;
        if (!we) o_rdata <= load_val;
      end
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_done     = (state == DONE);
  assign o_err      = (state == DONE) && err;
  assign o_ram_addr = addr;
  assign o_ram_val  = (state == WR) ? merge_val : 32'd0;

  // gated by reset so a reset landing in WR never commits the write
  always_comb begin
    o_ram_action = `RAM_NOP;
    if (!i_rst) begin
      if (state == RD)      o_ram_action = `RAM_READ;
      else if (state == WR) o_ram_action = `RAM_WRITE;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-array RAM, byte-level reference model, random + directed ops.
`ifndef RAM_NOP
`define RAM_NOP   2'b00
`endif
`ifndef RAM_READ
`define RAM_READ  2'b01
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'b10
`endif

module tb_mem_lsu;
  localparam int MEM_SIZE = 4096;

  logic        i_clk = 0, i_rst = 1, i_req = 0, i_we = 0, i_signed = 0;
  logic [1:0]  i_size = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, i_ram_val;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_rdata, o_ram_addr, o_ram_val;
  logic [1:0]  o_ram_action;

  mem_lsu #(.MEM_SIZE(MEM_SIZE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_signed(i_signed), .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .o_ram_action(o_ram_action),
    .o_ram_addr(o_ram_addr), .o_ram_val(o_ram_val), .i_ram_val(i_ram_val)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] mem     [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];
  int cyc = 0, tests = 0, fails = 0, nrd = 0, nwr = 0;
  logic [31:0] last_rdata = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat, nrd, nwr, acc;
  } exp_t;
  exp_t q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // RAM: combinational big-endian read, write on the clock edge
  wire addr_ok = (o_ram_addr <= 32'(MEM_SIZE - 4));
  assign i_ram_val = addr_ok ? {mem[int'(o_ram_addr)], mem[int'(o_ram_addr) + 1],
                                mem[int'(o_ram_addr) + 2], mem[int'(o_ram_addr) + 3]} : 32'd0;
  always @(posedge i_clk)
    if (o_ram_action == `RAM_WRITE && addr_ok)
      for (int i = 0; i < 4; i++) mem[int'(o_ram_addr) + i] <= o_ram_val[31 - 8*i -: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: counts RAM actions per request and compares on every o_done
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      nrd = 0; nwr = 0;
    end else begin
      if (o_ram_action == `RAM_READ)  nrd++;
      if (o_ram_action == `RAM_WRITE) nwr++;
      if (o_done) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("err",     32'(o_err), 32'(e.err));
          chk("rdata",   o_rdata, e.rdata);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("n_read",  32'(nrd), 32'(e.nrd));
          chk("n_write", 32'(nwr), 32'(e.nwr));
        end
        nrd = 0; nwr = 0;
      end
    end
  end

  // reference model: byte-level behaviour of one access
  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    logic [31:0] v;
    e.acc = cyc;
    e.err = (sz == 2'b11) || (a > 32'(MEM_SIZE - 4));
    e.rdata = last_rdata; e.lat = 1; e.nrd = 0; e.nwr = 0;
    if (!e.err) begin
      n = 1 << sz;
      if (!we) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        last_rdata = v;
        e.rdata = v; e.lat = 2; e.nrd = 1;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
        e.lat = (n == 4) ? 2 : 3; e.nrd = (n == 4) ? 0 : 1; e.nwr = 1;
      end
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (o_busy && n < 50) begin @(negedge i_clk); n++; end
    if (o_busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit track = 1);
    wait_idle();
    i_we = we; i_size = sz; i_signed = sg; i_addr = a; i_wdata = wd; i_req = 1;
    if (track) q.push_back(model(we, sz, sg, a, wd));
    @(posedge i_clk); #1 i_req = 0;
  endtask

  initial begin
    int n, mism;
    for (int i = 0; i < MEM_SIZE; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end

    // reset held with i_req toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_req = ~i_req;
      #1;
      chk("rst_action", 32'(o_ram_action), 32'(`RAM_NOP));
      chk("rst_busy",   32'(o_busy), 32'd0);
      chk("rst_done",   32'(o_done), 32'd0);
    end
    @(negedge i_clk); i_req = 0; i_rst = 0;

    // word store/load, byte RMW, signed/unsigned sub-word loads
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h10, 0);
    issue(1, 2'b00, 0, 32'h11, 32'h80);
    wait_idle();
    chk("mem_word_0x10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDE80BEEF);
    issue(0, 2'b00, 1, 32'h11, 0);
    issue(0, 2'b00, 0, 32'h11, 0);
    issue(1, 2'b01, 0, 32'h20, 32'h1234);
    issue(0, 2'b01, 1, 32'h20, 0);
    issue(1, 2'b01, 0, 32'h20, 32'hF00D);
    issue(0, 2'b01, 1, 32'h20, 0);
    // errors: window past the end, illegal size, last legal address
    issue(1, 2'b00, 0, 32'(MEM_SIZE - 3), 32'hAA);
    issue(0, 2'b11, 0, 32'h10, 0);
    issue(1, 2'b11, 0, 32'h10, 32'h55);
    issue(1, 2'b10, 0, 32'(MEM_SIZE - 4), 32'h01020304);
    issue(0, 2'b00, 0, 32'(MEM_SIZE - 4), 0);

    // reset during the WR cycle of a byte store
    issue(1, 2'b00, 0, 32'h30, 32'h5A, 0);
    n = 0;
    while (o_ram_action != `RAM_WRITE && n < 5) begin @(negedge i_clk); n++; end
    chk("saw_wr_cycle", 32'(o_ram_action), 32'(`RAM_WRITE));
    #1 i_rst = 1;
    #1 chk("rst_in_wr_action", 32'(o_ram_action), 32'(`RAM_NOP));
    @(posedge i_clk); @(negedge i_clk);
    chk("after_rst_busy", 32'(o_busy), 32'd0);
    chk("after_rst_done", 32'(o_done), 32'd0);
    #1 i_rst = 0;
    last_rdata = 0;
    issue(0, 2'b10, 0, 32'h30, 0);

    // request while busy is dropped
    issue(0, 2'b10, 0, 32'h10, 0);
    i_req = 1; i_we = 1; i_size = 2'b10; i_addr = 32'h40; i_wdata = 32'hCAFEF00D;
    @(posedge i_clk); @(posedge i_clk); #1 i_req = 0;
    repeat (6) @(negedge i_clk);
    chk("dropped_req_queue", 32'(q.size()), 32'd0);
    chk("dropped_req_mem", {mem[64], mem[65], mem[66], mem[67]},
        {ref_mem[64], ref_mem[65], ref_mem[66], ref_mem[67]});

    // random mix
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(MEM_SIZE - 8, MEM_SIZE + 4))
                                      : 32'($urandom_range(0, 63));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge i_clk); n++; end
    chk("drain_queue", 32'(q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
